dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 15: word-address width of the shared data memory.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 mN_req  input  1  requester N (N = 0, 1) access request; held with its payload until mN_gnt.
REQ-005 mN_we  input  1  requester N: 1 = write, 0 = read.
REQ-006 mN_addr  input  ADDR_W  requester N word address.
REQ-007 mN_wdata  input  32  requester N write data.
REQ-008 mN_be  input  4  requester N byte enables for writes.
REQ-009 mN_gnt  output  1  requester N request accepted this cycle.
REQ-010 mN_rvalid  output  1  requester N read data valid this cycle.
REQ-011 mN_rdata  output  32  requester N read data; equals mem_q when mN_rvalid = 1, else 0.
REQ-012 mem_rdaddress, mem_wraddress  output  ADDR_W  memory read and write addresses.
REQ-013 mem_data  output  32  memory write data.
REQ-014 mem_byteena  output  4  memory byte enables.
REQ-015 mem_wren  output  1  memory write enable.
REQ-016 mem_q  input  32  memory read data, registered inside the memory, valid one cycle after the address.

Function
REQ-017 FSM states: IDLE and RD_WAIT; a 1-bit owner register records the requester of the in-flight read.
REQ-018 IDLE with at least one mN_req = 1: exactly one mN_gnt is asserted combinationally in the same cycle.
REQ-019 Grant cycle: mem_rdaddress = mem_wraddress = granted mN_addr; mem_data = mN_wdata; mem_byteena = mN_be; mem_wren = mN_we.
REQ-020 Non-grant cycles: mem_wren = 0; address, data and byteena outputs = 0.
REQ-021 Granted write: completes at the grant edge; the FSM stays in IDLE (1-cycle write, back-to-back writes allowed).
REQ-022 Granted read: IDLE -> RD_WAIT, owner <= granted N.
REQ-023 RD_WAIT: m[owner]_rvalid = 1 and m[owner]_rdata = mem_q; no grant is issued; next state is IDLE unconditionally (2-cycle read occupancy).
REQ-024 Exactly one of m0_rvalid and m1_rvalid is asserted per read; never both; never in IDLE.
REQ-025 Both requesting in IDLE: the winner is chosen per REQ-034/REQ-035; the loser keeps its mN_req and is granted in a later IDLE cycle.
REQ-026 mN_req deasserted before grant: the request is dropped with no side effect. mN_req values during RD_WAIT are ignored until IDLE.
REQ-027 Priority pointer last (1 bit) updates to N on every grant to N, including write grants.

Reset
REQ-028 rst = 1 at a clock edge: state <= IDLE, owner <= 0, last <= 1.
REQ-029 While rst = 1: all mN_gnt, mN_rvalid and mem_wren = 0; all other outputs = 0.
REQ-030 Reset during RD_WAIT aborts the read; no rvalid is produced after reset deasserts.
REQ-031 The first cycle after reset is IDLE with m0 favoured, since last = 1.

Configuration
REQ-032 Macro DMEM_ARB_RR_EN selects the arbitration policy.
REQ-033 The policy affects only the choice of winner in REQ-025; all timing is identical in both builds.
REQ-034 Defined: round-robin; on conflict, grant the requester not equal to last.
REQ-035 Undefined: fixed priority; on conflict m0 always wins; last is still maintained but unused.

Verification
REQ-036 m0 write addr 0x0010, wdata 0xDEADBEEF, be 4'b1111, then m1 read addr 0x0010 -> m0_gnt same cycle; m1_gnt next cycle; m1_rvalid one cycle after that with m1_rdata = 0xDEADBEEF.
REQ-037 Write be 4'b0010, wdata 0x0000AB00 over 0x11223344 at addr 0x0005, then read -> rdata = 0x1122AB44.
REQ-038 Both hold read requests for 8 cycles, RR build -> grant order m0, m1, m0, m1, one grant per 2 cycles. Fixed build -> m0 every 2 cycles, m1 never granted.
REQ-039 m0 read granted, rst pulsed 1 cycle in RD_WAIT -> m0_rvalid never asserts; next IDLE grants m0 first.
REQ-040 m1 four consecutive writes to 0x7FFF..0x7FFC -> m1_gnt on 4 consecutive cycles; mem_wren high on 4 consecutive cycles; no rvalid asserted.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of a single-port data memory with registered read data.
// Define DMEM_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority (m0 wins).
module dmem_arbiter #(
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [3:0]        m0_be,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [31:0]       m0_rdata,

  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [3:0]        m1_be,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [31:0]       m1_rdata,

  output logic [ADDR_W-1:0] mem_rdaddress,
  output logic [ADDR_W-1:0] mem_wraddress,
  output logic [31:0]       mem_data,
  output logic [3:0]        mem_byteena,
  output logic              mem_wren,
  input  logic [31:0]       mem_q
);

  localparam logic ST_IDLE    = 1'b0;
  localparam logic ST_RD_WAIT = 1'b1;

`ifdef DMEM_ARB_RR_EN
  localparam logic RR_EN = 1'b1;
`else
  localparam logic RR_EN = 1'b0;
`endif

  logic state;
  logic owner;
  logic last;

  logic in_idle;
  logic in_rd_wait;
  logic any_req;
  logic both_req;
  logic sel;
  logic sel_we;

  // Winner select: sel = 1 means m1. On conflict only the round-robin build consults last.
  always_comb begin
    in_idle    = !rst && (state == ST_IDLE);
    in_rd_wait = !rst && (state == ST_RD_WAIT);
    any_req    = m0_req || m1_req;
    both_req   = m0_req && m1_req;
    if (both_req) begin
      sel = RR_EN & ~last;
    end else begin
      sel = ~m0_req;
    end
    sel_we = sel ? m1_we : m0_we;
  end

  always_comb begin
    m0_gnt = in_idle && any_req && !sel;
    m1_gnt = in_idle && any_req && sel;
  end

  // The memory port carries the granted payload only; every other cycle drives zeros.
  always_comb begin
    mem_rdaddress = '0;
    mem_wraddress = '0;
    mem_data      = '0;
    mem_byteena   = '0;
    mem_wren      = 1'b0;
    if (m0_gnt) begin
      mem_rdaddress = m0_addr;
      mem_wraddress = m0_addr;
      mem_data      = m0_wdata;
      mem_byteena   = m0_be;
      mem_wren      = m0_we;
    end else if (m1_gnt) begin
      mem_rdaddress = m1_addr;
      mem_wraddress = m1_addr;
      mem_data      = m1_wdata;
      mem_byteena   = m1_be;
      mem_wren      = m1_we;
    end
  end

  always_comb begin
    m0_rvalid = in_rd_wait && !owner;
    m1_rvalid = in_rd_wait && owner;
    m0_rdata  = m0_rvalid ? mem_q : 32'h0;
    m1_rdata  = m1_rvalid ? mem_q : 32'h0;
  end

  // Writes finish at the grant edge; reads hold the arbiter one extra cycle for mem_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      owner <= 1'b0;
      last  <= 1'b1;
    end else if (state == ST_IDLE) begin
      if (any_req) begin
        last <= sel;
        if (!sel_we) begin
          state <= ST_RD_WAIT;
          owner <= sel;
        end
      end
    end else begin
      state <= ST_IDLE;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: per-cycle vector table plus hand sequences for
// arbitration fairness and reset abort. Expectations follow DMEM_ARB_RR_EN when defined.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [14:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic [3:0]  m0_be, m1_be;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [14:0] mem_rdaddress, mem_wraddress;
  logic [31:0] mem_data;
  logic [3:0]  mem_byteena;
  logic        mem_wren;
  logic [31:0] mem_q;

  int tests_run = 0;
  int tests_failed = 0;

  dmem_arbiter #(.ADDR_W(15)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_rdaddress(mem_rdaddress), .mem_wraddress(mem_wraddress), .mem_data(mem_data),
    .mem_byteena(mem_byteena), .mem_wren(mem_wren), .mem_q(mem_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory: byte-enabled writes, read data registered one cycle after the address.
  logic [31:0] mem [0:32767];
  initial begin
    for (int k = 0; k < 32768; k++) mem[k] = 32'h0;
  end
  always @(posedge clk) begin
    if (mem_wren) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_byteena[b]) mem[mem_wraddress][8*b +: 8] <= mem_data[8*b +: 8];
      end
    end
    mem_q <= mem[mem_rdaddress];
  end

  typedef struct {
    logic        r0, we0;
    logic [14:0] a0;
    logic [31:0] d0;
    logic [3:0]  be0;
    logic        r1, we1;
    logic [14:0] a1;
    logic [31:0] d1;
    logic [3:0]  be1;
    logic        g0, g1, v0, v1;
    logic [31:0] q0, q1;
    logic        wren;
    logic [14:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } vec_t;

  vec_t tbl [16];

  task automatic applyStimulus(input vec_t v);
    m0_req = v.r0; m0_we = v.we0; m0_addr = v.a0; m0_wdata = v.d0; m0_be = v.be0;
    m1_req = v.r1; m1_we = v.we1; m1_addr = v.a1; m1_wdata = v.d1; m1_be = v.be1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkVector(input int idx, input vec_t v);
    checkOutput($sformatf("v%0d m0_gnt", idx), {31'h0, m0_gnt}, {31'h0, v.g0});
    checkOutput($sformatf("v%0d m1_gnt", idx), {31'h0, m1_gnt}, {31'h0, v.g1});
    checkOutput($sformatf("v%0d m0_rvalid", idx), {31'h0, m0_rvalid}, {31'h0, v.v0});
    checkOutput($sformatf("v%0d m1_rvalid", idx), {31'h0, m1_rvalid}, {31'h0, v.v1});
    checkOutput($sformatf("v%0d m0_rdata", idx), m0_rdata, v.q0);
    checkOutput($sformatf("v%0d m1_rdata", idx), m1_rdata, v.q1);
    checkOutput($sformatf("v%0d mem_wren", idx), {31'h0, mem_wren}, {31'h0, v.wren});
    checkOutput($sformatf("v%0d mem_wraddress", idx), {17'h0, mem_wraddress}, {17'h0, v.addr});
    checkOutput($sformatf("v%0d mem_rdaddress", idx), {17'h0, mem_rdaddress}, {17'h0, v.addr});
    checkOutput($sformatf("v%0d mem_data", idx), mem_data, v.data);
    checkOutput($sformatf("v%0d mem_byteena", idx), {28'h0, mem_byteena}, {28'h0, v.be});
  endtask

  task automatic setReqs(input logic r0, input logic [14:0] a0, input logic r1, input logic [14:0] a1);
    m0_req = r0; m0_we = 1'b0; m0_addr = a0; m0_wdata = 32'h0; m0_be = 4'h0;
    m1_req = r1; m1_we = 1'b0; m1_addr = a1; m1_wdata = 32'h0; m1_be = 4'h0;
  endtask

  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  int exp_win [4];

  initial begin
    // Reset held with a pending m0 write: nothing may reach the memory port.
    rst = 1'b1;
    setReqs(1'b1, 15'h0010, 1'b1, 15'h0005);
    m0_we = 1'b1; m0_wdata = 32'hCAFEF00D; m0_be = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset m0_gnt", {31'h0, m0_gnt}, 32'h0);
    checkOutput("reset m1_gnt", {31'h0, m1_gnt}, 32'h0);
    checkOutput("reset mem_wren", {31'h0, mem_wren}, 32'h0);
    checkOutput("reset mem_rdaddress", {17'h0, mem_rdaddress}, 32'h0);
    checkOutput("reset mem_data", mem_data, 32'h0);
    checkOutput("reset rvalid", {30'h0, m0_rvalid, m1_rvalid}, 32'h0);
    nextCycle();
    rst = 1'b0;

    //            r0 we0 a0        d0            be0   r1 we1 a1        d1            be1   g0 g1 v0 v1 q0            q1            wren addr      data          be
    tbl[0]  = '{1, 1, 15'h0010, 32'hDEADBEEF, 4'hF, 1, 0, 15'h0010, 32'h0,        4'h0, 1, 0, 0, 0, 32'h0,        32'h0,        1, 15'h0010, 32'hDEADBEEF, 4'hF};
    tbl[1]  = '{0, 0, 15'h0000, 32'h0,        4'h0, 1, 0, 15'h0010, 32'h0,        4'h0, 0, 1, 0, 0, 32'h0,        32'h0,        0, 15'h0010, 32'h0,        4'h0};
    tbl[2]  = '{0, 0, 15'h0000, 32'h0,        4'h0, 0, 0, 15'h0000, 32'h0,        4'h0, 0, 0, 0, 1, 32'h0,        32'hDEADBEEF, 0, 15'h0000, 32'h0,        4'h0};
    tbl[3]  = '{1, 1, 15'h0005, 32'h11223344, 4'hF, 0, 0, 15'h0000, 32'h0,        4'h0, 1, 0, 0, 0, 32'h0,        32'h0,        1, 15'h0005, 32'h11223344, 4'hF};
    tbl[4]  = '{1, 1, 15'h0005, 32'h0000AB00, 4'h2, 0, 0, 15'h0000, 32'h0,        4'h0, 1, 0, 0, 0, 32'h0,        32'h0,        1, 15'h0005, 32'h0000AB00, 4'h2};
    tbl[5]  = '{1, 0, 15'h0005, 32'h0,        4'h0, 0, 0, 15'h0000, 32'h0,        4'h0, 1, 0, 0, 0, 32'h0,        32'h0,        0, 15'h0005, 32'h0,        4'h0};
    tbl[6]  = '{0, 0, 15'h0000, 32'h0,        4'h0, 1, 0, 15'h0010, 32'h0,        4'h0, 0, 0, 1, 0, 32'h1122AB44, 32'h0,        0, 15'h0000, 32'h0,        4'h0};
    tbl[7]  = '{0, 0, 15'h0000, 32'h0,        4'h0, 1, 0, 15'h0010, 32'h0,        4'h0, 0, 1, 0, 0, 32'h0,        32'h0,        0, 15'h0010, 32'h0,        4'h0};
    tbl[8]  = '{0, 0, 15'h0000, 32'h0,        4'h0, 0, 0, 15'h0000, 32'h0,        4'h0, 0, 0, 0, 1, 32'h0,        32'hDEADBEEF, 0, 15'h0000, 32'h0,        4'h0};
    tbl[9]  = '{0, 0, 15'h0000, 32'h0,        4'h0, 0, 0, 15'h0000, 32'h0,        4'h0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 15'h0000, 32'h0,        4'h0};
    tbl[10] = '{0, 0, 15'h0000, 32'h0,        4'h0, 1, 1, 15'h7FFF, 32'hA0000000, 4'hF, 0, 1, 0, 0, 32'h0,        32'h0,        1, 15'h7FFF, 32'hA0000000, 4'hF};
    tbl[11] = '{0, 0, 15'h0000, 32'h0,        4'h0, 1, 1, 15'h7FFE, 32'hA0000001, 4'hF, 0, 1, 0, 0, 32'h0,        32'h0,        1, 15'h7FFE, 32'hA0000001, 4'hF};
    tbl[12] = '{0, 0, 15'h0000, 32'h0,        4'h0, 1, 1, 15'h7FFD, 32'hA0000002, 4'hF, 0, 1, 0, 0, 32'h0,        32'h0,        1, 15'h7FFD, 32'hA0000002, 4'hF};
    tbl[13] = '{0, 0, 15'h0000, 32'h0,        4'h0, 1, 1, 15'h7FFC, 32'hA0000003, 4'hF, 0, 1, 0, 0, 32'h0,        32'h0,        1, 15'h7FFC, 32'hA0000003, 4'hF};
    tbl[14] = '{1, 0, 15'h7FFE, 32'h0,        4'h0, 0, 0, 15'h0000, 32'h0,        4'h0, 1, 0, 0, 0, 32'h0,        32'h0,        0, 15'h7FFE, 32'h0,        4'h0};
    tbl[15] = '{0, 0, 15'h0000, 32'h0,        4'h0, 0, 0, 15'h0000, 32'h0,        4'h0, 0, 0, 1, 0, 32'hA0000001, 32'h0,        0, 15'h0000, 32'h0,        4'h0};

    for (int i = 0; i < 16; i++) begin
      applyStimulus(tbl[i]);
      @(negedge clk);
      checkVector(i, tbl[i]);
      nextCycle();
    end

    // Both requesters hold reads for 8 cycles straight after a reset.
`ifdef DMEM_ARB_RR_EN
    exp_win = '{0, 1, 0, 1};
`else
    exp_win = '{0, 0, 0, 0};
`endif
    setReqs(1'b0, 15'h0, 1'b0, 15'h0);
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    setReqs(1'b1, 15'h0010, 1'b1, 15'h0005);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c % 2 == 0) begin
        checkOutput($sformatf("conflict c%0d m0_gnt", c), {31'h0, m0_gnt}, (exp_win[c/2] == 0) ? 32'h1 : 32'h0);
        checkOutput($sformatf("conflict c%0d m1_gnt", c), {31'h0, m1_gnt}, (exp_win[c/2] == 1) ? 32'h1 : 32'h0);
        checkOutput($sformatf("conflict c%0d rvalid", c), {30'h0, m0_rvalid, m1_rvalid}, 32'h0);
      end else begin
        checkOutput($sformatf("conflict c%0d gnt", c), {30'h0, m0_gnt, m1_gnt}, 32'h0);
        checkOutput($sformatf("conflict c%0d rvalid", c), {30'h0, m0_rvalid, m1_rvalid},
                    (exp_win[c/2] == 0) ? 32'h2 : 32'h1);
        checkOutput($sformatf("conflict c%0d rdata", c), m0_rdata | m1_rdata,
                    (exp_win[c/2] == 0) ? 32'hDEADBEEF : 32'h1122AB44);
      end
      nextCycle();
    end

    // m0 read granted, then reset lands in RD_WAIT and must swallow the read.
    setReqs(1'b1, 15'h0010, 1'b0, 15'h0);
    @(negedge clk);
    checkOutput("abort m0_gnt", {31'h0, m0_gnt}, 32'h1);
    nextCycle();
    setReqs(1'b0, 15'h0, 1'b0, 15'h0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort rvalid in reset", {30'h0, m0_rvalid, m1_rvalid}, 32'h0);
    nextCycle();
    rst = 1'b0;
    setReqs(1'b1, 15'h0010, 1'b1, 15'h0005);
    @(negedge clk);
    checkOutput("post-reset rvalid", {30'h0, m0_rvalid, m1_rvalid}, 32'h0);
    checkOutput("post-reset m0_gnt", {31'h0, m0_gnt}, 32'h1);
    checkOutput("post-reset m1_gnt", {31'h0, m1_gnt}, 32'h0);
    nextCycle();
    setReqs(1'b0, 15'h0, 1'b0, 15'h0);
    @(negedge clk);
    checkOutput("post-reset m0_rvalid", {31'h0, m0_rvalid}, 32'h1);
    checkOutput("post-reset m0_rdata", m0_rdata, 32'hDEADBEEF);
    nextCycle();
    @(negedge clk);
    checkOutput("idle rvalid", {30'h0, m0_rvalid, m1_rvalid}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
